// File: rtl/fifo_uart_sequencer.sv
// Word/byte sequencer between the AXI-side TX/RX word FIFOs and a byte-wide UART core.
// Optional idle-timeout flush of a partial RX word: define FIFO_UART_RX_FLUSH_EN.
module fifo_uart_sequencer #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BYTES_PER_WORD = AXI_DATA_WIDTH / 8,
    parameter int RX_TIMEOUT     = 1024
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESETN,
    input  logic                      tx_en,
    output logic                      read_fifo_tx,
    input  logic                      empty_tx,
    input  logic [AXI_DATA_WIDTH-1:0] fifo_r_data_tx,
    output logic [7:0]                uart_tx_data,
    output logic                      uart_tx_valid,
    input  logic                      uart_tx_ready,
    input  logic [7:0]                uart_rx_data,
    input  logic                      uart_rx_valid,
    output logic                      write_fifo_rx,
    input  logic                      full_rx,
    output logic [AXI_DATA_WIDTH-1:0] fifo_w_data_rx,
    output logic                      tx_active,
    output logic [7:0]                rx_overflow_cnt,
    output logic                      rx_flush
);

    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    if ((AXI_DATA_WIDTH % 8) != 0 || BYTES_PER_WORD != AXI_DATA_WIDTH / 8 || RX_TIMEOUT < 1) begin : g_cfg_check
        $error("fifo_uart_sequencer: invalid parameter combination");
    end

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---------------- TX: word pop and byte serialiser ----------------
    typedef enum logic {IDLE, SEND} tx_state_t;

    tx_state_t                 state_q, state_d;
    logic [AXI_DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]          tx_idx_q;
    logic                      tx_vld_q;
    logic                      tx_xfer, tx_last, tx_pop;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        tx_xfer = tx_vld_q && uart_tx_ready;
        tx_last = tx_xfer && (tx_idx_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                if (tx_en && !empty_tx) begin
                    tx_pop  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Refill on the last byte keeps the byte stream gap-free across words.
                if (tx_last) begin
                    if (tx_en && !empty_tx) begin
                        tx_pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            shift_q  <= '0;
            tx_idx_q <= '0;
            tx_vld_q <= 1'b0;
        end else if (tx_pop) begin
            shift_q  <= fifo_r_data_tx;
            tx_idx_q <= '0;
            tx_vld_q <= 1'b1;
        end else if (tx_xfer) begin
            shift_q  <= shift_q >> 8;
            tx_idx_q <= tx_idx_q + IDX_W'(1);
            if (tx_last) begin
                tx_vld_q <= 1'b0;
            end
        end
    end

    assign read_fifo_tx  = tx_pop && S_AXI_ARESETN;
    assign uart_tx_data  = shift_q[7:0];
    assign uart_tx_valid = tx_vld_q;
    assign tx_active     = (state_q == SEND);

    // ---------------- RX stage p0: little-endian byte packer ----------------
    logic [AXI_DATA_WIDTH-1:0] rx_word_p0, rx_word_nxt, word_p1;
    logic [IDX_W-1:0]          rx_idx_p0;
    logic                      rx_done, rx_timeout;
    logic                      vld_p1, flush_p1;
    logic [7:0]                ovf_cnt_q;

    always_comb begin
        rx_word_nxt = rx_word_p0;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (rx_idx_p0 == IDX_W'(b)) begin
                rx_word_nxt[8*b +: 8] = uart_rx_data;
            end
        end
        rx_done = uart_rx_valid && (rx_idx_p0 == LAST_IDX);
    end

`ifdef FIFO_UART_RX_FLUSH_EN
    localparam int CNT_W = $clog2(RX_TIMEOUT + 1);

    logic [CNT_W-1:0] idle_cnt_q;

    assign rx_timeout = !uart_rx_valid && (rx_idx_p0 != '0) &&
                        (idle_cnt_q == CNT_W'(RX_TIMEOUT - 1));

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || uart_rx_valid || rx_idx_p0 == '0 || rx_timeout) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
    end
`else
    assign rx_timeout = 1'b0;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rx_word_p0 <= '0;
            rx_idx_p0  <= '0;
            word_p1    <= '0;
            vld_p1     <= 1'b0;
            flush_p1   <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            vld_p1   <= 1'b0;
            flush_p1 <= 1'b0;
            if (uart_rx_valid) begin
                if (rx_done) begin
                    word_p1    <= rx_word_nxt;
                    vld_p1     <= 1'b1;
                    rx_word_p0 <= '0;
                    rx_idx_p0  <= '0;
                end else begin
                    rx_word_p0 <= rx_word_nxt;
                    rx_idx_p0  <= rx_idx_p0 + IDX_W'(1);
                end
            end else if (rx_timeout) begin
                // Cleared upper bytes give the zero padding of a flushed word.
                word_p1    <= rx_word_p0;
                vld_p1     <= 1'b1;
                flush_p1   <= 1'b1;
                rx_word_p0 <= '0;
                rx_idx_p0  <= '0;
            end
            if (vld_p1 && full_rx) begin
                ovf_cnt_q <= sat_inc8(ovf_cnt_q);
            end
        end
    end

    // ---------------- RX stage p1: push decision against full_rx ----------------
    assign write_fifo_rx   = vld_p1 && !full_rx && S_AXI_ARESETN;
    assign fifo_w_data_rx  = word_p1;
    assign rx_flush        = write_fifo_rx && flush_p1;
    assign rx_overflow_cnt = ovf_cnt_q;

endmodule

// File: doc/fifo_uart_sequencer.md
Name: fifo_uart_sequencer

Overview:
Byte-level controller between the AXI-side TX/RX word FIFOs and a byte-wide UART core.
- TX: pops 32-bit words from the TX FIFO and serialises each into 4 bytes, LSB first, over a valid/ready byte interface.
- RX: packs incoming bytes (little-endian) into 32-bit words and pushes them into the RX FIFO.
- Also provides overflow accounting and a TX enable gate.

Parameters:
- AXI_DATA_WIDTH, 32, FIFO word width; must be a multiple of 8.
- BYTES_PER_WORD, AXI_DATA_WIDTH/8, bytes per word (derived; do not override).
- RX_TIMEOUT, 1024, idle cycles before a partial RX word is flushed (used only with the optional feature).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset; synchronous, active-low.
- tx_en  in  1  enables popping new TX words; an in-flight word always completes.
- read_fifo_tx  out  1  TX FIFO pop strobe, 1 cycle.
- empty_tx  in  1  TX FIFO empty.
- fifo_r_data_tx  in  AXI_DATA_WIDTH  TX FIFO head word; first-word fall-through, valid while !empty_tx.
- uart_tx_data  out  8  byte to UART.
- uart_tx_valid  out  1  byte valid.
- uart_tx_ready  in  1  UART accepts byte.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  1-cycle strobe per received byte; no backpressure.
- write_fifo_rx  out  1  RX FIFO push strobe, 1 cycle.
- full_rx  in  1  RX FIFO full.
- fifo_w_data_rx  out  AXI_DATA_WIDTH  word to push.
- tx_active  out  1  a word is being serialised.
- rx_overflow_cnt  out  8  count of dropped RX words, saturating at 255.
- rx_flush  out  1  pulses with write_fifo_rx when the pushed word is a partial flush.

Behaviour:
Reset (S_AXI_ARESETN low at a clock edge):
- All outputs go to 0. State returns to IDLE, byte indices to 0, shift registers to 0.
- A partial TX or RX word is discarded. Reset mid-byte gives no UART handshake completion.

TX FSM: states IDLE, SEND.
- IDLE: if tx_en && !empty_tx, then:
  - read_fifo_tx=1 for that cycle;
  - shift register <= fifo_r_data_tx; tx_idx <= 0;
  - next state SEND.
- SEND:
  - uart_tx_valid=1 and uart_tx_data=shift[7:0], both registered.
  - uart_tx_valid is held, with data stable, until uart_tx_valid && uart_tx_ready.
  - On each transfer: shift >>= 8, tx_idx++.
- On the transfer with tx_idx==BYTES_PER_WORD-1:
  - if tx_en && !empty_tx, pop the next word in that same cycle and stay in SEND (back-to-back, no bubble byte);
  - otherwise uart_tx_valid<=0 and go to IDLE.
- Timing:
  - Latency from empty_tx falling (with tx_en=1) to the first uart_tx_valid is 2 cycles: the pop cycle plus the registered output.
  - Exactly one pop per word; no pop while empty_tx=1.
- tx_active = (state==SEND).
- tx_en falling mid-word does not abort the current word.

RX packer:
- On uart_rx_valid: rx_word[8*rx_idx +: 8] <= uart_rx_data; rx_idx++ (wraps modulo BYTES_PER_WORD).
- When the byte with rx_idx==BYTES_PER_WORD-1 arrives, in the next cycle:
  - if !full_rx: write_fifo_rx=1 and fifo_w_data_rx = completed word;
  - if full_rx: the word is dropped and rx_overflow_cnt increments, saturating at 255.
- fifo_w_data_rx is registered and stable while write_fifo_rx=1.
- A new byte arriving in the push cycle goes into the next word; no loss.
- full_rx is sampled in the push-decision cycle only.
- RX and TX paths are fully independent; simultaneous activity is legal.

Optional Feature:
Macro: FIFO_UART_RX_FLUSH_EN.
- Defined:
  - an idle counter resets on every uart_rx_valid and counts while 0<rx_idx<BYTES_PER_WORD;
  - at RX_TIMEOUT cycles the partial word is pushed, zero-padded in the upper bytes, with rx_flush=1 in the same cycle;
  - rx_idx <= 0;
  - full_rx at flush time drops the word and increments rx_overflow_cnt.
- Undefined: no counter; a partial word waits indefinitely; rx_flush is tied 0.

Test Plan:
1. Reset, then push 0x44332211 into the TX FIFO with tx_en=1 and uart_tx_ready=1 → exactly one read_fifo_tx pulse; bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; then uart_tx_valid=0 and tx_active=0.
2. Two words queued, 0xA3A2A1A0 and 0xB3B2B1B0, uart_tx_ready=1 → 8 consecutive valid bytes A0..A3, B0..B3 with no gap; a pop coincides with the A3 transfer.
3. uart_tx_ready toggling 1,0,0,1 during a word → uart_tx_data holds each byte stable while stalled; no byte skipped or duplicated. Drop tx_en mid-word → the word finishes and no new pop occurs.
4. RX bytes 0xEF, 0xBE, 0xAD, 0xDE → one write_fifo_rx with fifo_w_data_rx=0xDEADBEEF, one cycle after the last byte. Repeat with full_rx=1 → no write; rx_overflow_cnt=1. Then 300 dropped words → rx_overflow_cnt=255.
5. Assert S_AXI_ARESETN low after 2 of 4 TX bytes and after 2 RX bytes → all outputs 0; on the next full RX word the data is correctly aligned from byte 0.
6. With FIFO_UART_RX_FLUSH_EN and RX_TIMEOUT=16: bytes 0x55, 0x66 then idle → after 16 idle cycles write_fifo_rx=1, rx_flush=1, data 0x00006655. Without the macro: no write ever occurs.
